// File: rtl/serial_mul3_tx.sv
// rtl/serial_mul3_tx.sv - serial transmitter of N = 3*q + r, LSB-first
//
// Rebuilds the dividend N = 3*q + r from a parallel quotient/remainder and
// shifts it out one bit per handshake, LSB-first, as a W+2 bit frame.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset
//   in_valid   q/r word presented
//   in_ready   block can accept a word (registered)
//   in_q       quotient, W bits
//   in_r       remainder, legal 0..2; 3 is consumed, dropped and flagged
//   out_valid  out_bit is valid
//   out_bit    current bit of N
//   out_last   marks bit index W+1, the final bit of the frame
//   out_ready  sink accepts the current bit
//   busy       frame in progress
//   err        one-cycle pulse after an illegal remainder was accepted

module serial_mul3_tx #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_q,
    input  logic [1:0]   in_r,
    output logic         out_valid,
    output logic         out_bit,
    output logic         out_last,
    input  logic         out_ready,
    output logic         busy,
    output logic         err
);

    localparam int IW = $clog2(W + 2);
    localparam logic [IW-1:0] LAST_IDX = IW'(W + 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [IW-1:0]   idx;
    logic [1:0]      carry;
    logic [W-1:0]    q_reg;
    logic            in_ready_r;
    logic            err_r;

    logic [W+1:0]    sh_a;
    logic [W+1:0]    sh_b;
    logic            bit_a;
    logic            bit_b;
    logic [2:0]      sum;
    logic            accept;
    logic            legal_accept;
    logic            bit_hs;
    logic            is_last;

    // 3*q = q + 2*q: bit i adds q[i] and q[i-1]. Zero-padding the two
    // operand copies makes out-of-range indices (i>=W for q, i==0 or
    // i==W+1 for 2*q) read as 0 without any index bound checks.
    always_comb begin
        sh_a  = {2'b00, q_reg} >> idx;
        sh_b  = {1'b0, q_reg, 1'b0} >> idx;
        bit_a = sh_a[0];
        bit_b = sh_b[0];
        sum   = {2'b00, bit_a} + {2'b00, bit_b} + {1'b0, carry};
    end

    always_comb begin
        accept       = (state == IDLE) && in_valid && in_ready_r;
        legal_accept = accept && (in_r != 2'd3);
        bit_hs       = (state == SEND) && out_ready;
        is_last      = (state == SEND) && (idx == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (legal_accept)     state_nx = SEND;
            SEND: if (bit_hs && is_last) state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            carry      <= '0;
            q_reg      <= '0;
            in_ready_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            // Ready follows the upcoming state, so it drops on the accept
            // edge and returns only after the last bit has been taken.
            in_ready_r <= (state_nx == IDLE);
            err_r      <= accept && (in_r == 2'd3);
            if (legal_accept) begin
                q_reg <= in_q;
                carry <= in_r;
                idx   <= '0;
            end else if (bit_hs) begin
                carry <= sum[2:1];
                idx   <= is_last ? '0 : idx + IW'(1);
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);
    assign out_bit   = (state == SEND) & sum[0];
    assign out_last  = is_last;
    assign err       = err_r;

endmodule

// File: tb/tb_serial_mul3_tx.sv
// tb/tb_serial_mul3_tx.sv - self-checking bench for serial_mul3_tx

module tb_serial_mul3_tx;

    localparam int W  = 8;
    localparam int NB = W + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_q = '0;
    logic [1:0]   in_r = '0;
    logic         out_valid;
    logic         out_bit;
    logic         out_last;
    logic         out_ready = 1'b0;
    logic         busy;
    logic         err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_mul3_tx #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_q      (in_q),
        .in_r      (in_r),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
    endtask

    // Sends q/r and checks the bit stream against N = 3*q + r. With rnd set
    // the sink stalls randomly; stop_after >= 0 returns after that many bits.
    task automatic run_frame(input logic [W-1:0] q, input logic [1:0] r,
                             input bit rnd, input int stop_after);
        logic [NB-1:0] n;
        int nv;
        int cnt;
        int cyc;
        nv = 3 * int'(q) + int'(r);
        n  = nv[NB-1:0];
        wait_ready();
        in_valid = 1'b1;
        in_q     = q;
        in_r     = r;
        @(negedge clk);
        in_valid = 1'b0;
        in_q     = W'($urandom);
        in_r     = 2'($urandom);
        check("accept_in_ready_low", 32'(in_ready), 32'd0);
        check("accept_busy", 32'(busy), 32'd1);
        cnt = 0;
        cyc = 0;
        while (cnt < NB && cyc < 200) begin
            if (cnt == stop_after) return;
            check("out_valid", 32'(out_valid), 32'd1);
            check("out_bit", 32'(out_bit), 32'(n[cnt]));
            check("out_last", 32'(out_last), 32'(cnt == NB - 1));
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_ready) cnt++;
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("frame_len", 32'(cnt), 32'(NB));
        check("done_out_valid", 32'(out_valid), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        check("done_in_ready", 32'(in_ready), 32'd1);
        check("final_carry", 32'(dut.carry), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_bit", 32'(out_bit), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        run_frame(8'h55, 2'd2, 1'b0, -1);
        run_frame(8'hFF, 2'd2, 1'b0, -1);
        run_frame(8'h00, 2'd0, 1'b0, -1);
        run_frame(8'h00, 2'd1, 1'b0, -1);
        run_frame(8'hA3, 2'd1, 1'b1, -1);

        // Illegal remainder: consumed, flagged for one cycle, no frame.
        wait_ready();
        in_valid = 1'b1;
        in_q     = 8'h12;
        in_r     = 2'd3;
        @(negedge clk);
        in_valid = 1'b0;
        check("illegal_err", 32'(err), 32'd1);
        check("illegal_out_valid", 32'(out_valid), 32'd0);
        check("illegal_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("illegal_err_clear", 32'(err), 32'd0);
        check("illegal_no_frame", 32'(out_valid), 32'd0);
        run_frame(8'h12, 2'd1, 1'b0, -1);

        // Reset in the middle of a frame.
        run_frame(8'hC6, 2'd2, 1'b0, 4);
        rst = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_out_last", 32'(out_last), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_release_ready", 32'(in_ready), 32'd1);
        run_frame(8'h01, 2'd0, 1'b0, -1);

        repeat (6) run_frame(W'($urandom), 2'($urandom_range(0, 2)), 1'b1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_mul3_tx.md
Name: serial_mul3_tx

Overview:
- Inverse partner of the serial divide-by-3 receiver: takes a parallel quotient q and remainder r, and serially transmits the reconstructed dividend N = 3*q + r, LSB-first.
- Intended as the stimulus/transmit end in the lab's serial arithmetic chain.
- Word-level valid/ready on input; bit-level valid/ready with a last marker on output.

Parameters:
- W, 8, quotient width in bits; output frame length is W+2 bits.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  q/r presented.
- in_ready  output  1  block can accept a word.
- in_q  input  W  quotient.
- in_r  input  2  remainder; legal values 0..2.
- out_valid  output  1  out_bit is valid.
- out_bit  output  1  current bit of N, LSB-first.
- out_last  output  1  marks bit index W+1, the final bit.
- out_ready  input  1  sink accepts the current bit.
- busy  output  1  high while a frame is in progress.
- err  output  1  one-cycle pulse: an illegal remainder was accepted.

Behaviour:
- Reset values (while rst=1, synchronous):
  - state=IDLE, idx=0, carry=0.
  - in_ready=0, out_valid=0, out_bit=0, out_last=0, busy=0, err=0.
- States: IDLE, SEND.
- IDLE:
  - in_ready=1 (registered, asserted the first cycle after rst deasserts).
  - Accept occurs when in_valid && in_ready.
  - in_r<=2 on accept: latch q_reg=in_q, carry=in_r, idx=0; next state SEND.
  - in_r==3 on accept: word is consumed and dropped; err=1 for exactly the next cycle; stay IDLE; no output bits.
- SEND:
  - in_ready=0, busy=1, out_valid=1.
  - First bit is valid the cycle after accept (latency 1).
- Bit computation, for bit index i = idx in 0..W+1:
  - a = q_reg[i] if i<W, else 0.
  - b = q_reg[i-1] if 1<=i<=W, else 0.
  - sum = a + b + carry, 3 bits wide, max value 4.
  - out_bit = sum[0]; out_last = (idx==W+1).
- On each out_valid && out_ready:
  - carry <= sum>>1 (range 0..2); idx <= idx+1.
  - If out_last: state <= IDLE, busy=0, in_ready=1 the following cycle. No same-cycle turnaround, so frames are separated by at least one idle cycle.
- Backpressure:
  - While out_ready=0, out_bit, out_last, idx and carry hold stable.
  - in_q/in_r changes during SEND are ignored.
- Width rule: N <= 3*(2^W-1)+2 < 2^(W+2). Carry after the final bit is always 0; the bench asserts this.
- idx counter width: clog2(W+2).
- Reset mid-frame: frame aborted immediately. All outputs go to reset values the next cycle. No further bits and no out_last.
- in_valid=1 held continuously: a new word is accepted on each IDLE cycle only.

Test Plan:
- W=8, q=0x55, r=2, out_ready=1 -> N=257. Bits LSB-first: 1,0,0,0,0,0,0,0,1,0. out_last high on the 10th bit only. in_ready returns 1 cycle after.
- q=0xFF, r=2 -> N=767=0x2FF. Bits: 1,1,1,1,1,1,1,1,0,1. Carry is 0 after the last bit.
- q=0x00, r=0 -> ten 0 bits, out_last on the 10th. Then q=0x00, r=1 -> bits 1 followed by nine 0s.
- q=0xA3, r=1, out_ready pseudo-random (about 50%) -> bit stream equals 3*163+1=490 (0x1EA): 0,1,0,1,0,1,1,1,1,0. Outputs stable while stalled. Exactly 10 handshakes.
- in_r=3, q=0x12 -> err pulses for 1 cycle, out_valid stays 0, in_ready remains 1. A following legal word transmits correctly.
- rst asserted after the 4th bit of a frame -> next cycle out_valid=0, busy=0, err=0, in_ready=0. After release, a new frame q=0x01, r=0 gives bits 1,1,0,0,0,0,0,0,0,0.
